reduce_gate_pipe: RTL and testbench

- Parametrised successor to the fixed-arity AND/OR gate cells: one N-input reduction gate with run-time selectable function (AND/OR/XOR and their inverses) and a per-input mask.
- Built as a 2-stage pipeline with a valid/ready handshake, so wide reductions close timing and can sit on streaming datapaths in the problem-3 top level.
- Stage 1 reduces fixed-size groups of inputs. Stage 2 reduces the group results and applies the inversion.

---
 rtl/gate_pkg.sv | 38 +++
 rtl/reduce_gate_pipe_group.sv | 20 ++
 rtl/reduce_gate_pipe.sv | 138 +++++++++++++
 tb/tb_reduce_gate_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared encodings for the reduction gate pipeline: mode codes, base-op enum and mode decode helpers.
package gate_pkg;

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2
  } base_op_e;

  // Value a masked-off input takes so it cannot change the reduction.
  function automatic logic identity_of(input logic [2:0] mode);
    return (mode == MODE_AND) || (mode == MODE_NAND);
  endfunction

  function automatic base_op_e base_of(input logic [2:0] mode);
    case (mode)
      MODE_AND, MODE_NAND: return OP_AND;
      MODE_OR,  MODE_NOR:  return OP_OR;
      default:             return OP_XOR;
    endcase
  endfunction

  function automatic logic inv_of(input logic [2:0] mode);
    return (mode == MODE_NAND) || (mode == MODE_NOR) || (mode == MODE_XNOR);
  endfunction

  function automatic logic illegal_of(input logic [2:0] mode);
    return mode > MODE_XNOR;
  endfunction

endpackage

// File: rtl/reduce_gate_pipe_group.sv
// Combinational W-input reduction with a selectable AND/OR/XOR base function.
module reduce_group
  import gate_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] data_i,
  input  base_op_e     op_i,
  output logic         res_o
);

  always_comb begin
    case (op_i)
      OP_AND:  res_o = &data_i;
      OP_OR:   res_o = |data_i;
      default: res_o = ^data_i;
    endcase
  end

endmodule

// File: rtl/reduce_gate_pipe.sv
// Two-stage N-input masked reduction gate with valid/ready handshake.
// Optional popcount output enabled by defining REDUCE_GATE_COUNT_EN.
module reduce_gate_pipe
  import gate_pkg::*;
#(
  parameter int N_INPUTS = 7,
  parameter int GROUP    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] in_data,
  input  logic [N_INPUTS-1:0] in_mask,
  input  logic [2:0]          in_mode,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_s,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
`ifdef REDUCE_GATE_COUNT_EN
  ,
  output logic [$clog2(N_INPUTS+1)-1:0] out_count
`endif
);

  localparam int NGROUPS = (N_INPUTS + GROUP - 1) / GROUP;
  localparam int CW      = $clog2(N_INPUTS + 1);
  localparam int GCW     = $clog2(GROUP + 1);

  logic                s1_valid_q, s2_valid_q;
  logic                s1_adv, s2_adv;
  logic [N_INPUTS-1:0] masked;
  logic [NGROUPS-1:0]  grp_d, grp_q;
  base_op_e            op_d, op_q;
  logic                inv_q, err_q;
  logic                fin_res;
  logic                out_s_d, out_s_q, out_err_q;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign op_d = base_of(in_mode);

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++)
      masked[i] = in_mask[i] ? in_data[i] : identity_of(in_mode);
  end

`ifdef REDUCE_GATE_COUNT_EN
  logic [NGROUPS-1:0][GCW-1:0] cnt_d, cnt_q;
  logic [CW-1:0]               cnt_sum, cnt_out_q;
`endif

  // Last group is only as wide as the inputs left over; no padding slots exist.
  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    localparam int LO = g * GROUP;
    localparam int HI = ((g + 1) * GROUP < N_INPUTS) ? (g + 1) * GROUP - 1 : N_INPUTS - 1;

    reduce_group #(.W(HI - LO + 1)) u_grp (
      .data_i (masked[HI:LO]),
      .op_i   (op_d),
      .res_o  (grp_d[g])
    );

`ifdef REDUCE_GATE_COUNT_EN
    logic [GCW-1:0] cnt;
    always_comb begin
      cnt = '0;
      for (int i = LO; i <= HI; i++) cnt = cnt + GCW'(in_data[i] & in_mask[i]);
    end
    assign cnt_d[g] = cnt;
`endif
  end

  reduce_group #(.W(NGROUPS)) u_fin (
    .data_i (grp_q),
    .op_i   (op_q),
    .res_o  (fin_res)
  );

  assign out_s_d = !err_q && (fin_res ^ inv_q);

`ifdef REDUCE_GATE_COUNT_EN
  always_comb begin
    cnt_sum = '0;
    for (int g = 0; g < NGROUPS; g++) cnt_sum = cnt_sum + CW'(cnt_q[g]);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      grp_q      <= '0;
      op_q       <= OP_AND;
      inv_q      <= 1'b0;
      err_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      out_s_q    <= 1'b0;
      out_err_q  <= 1'b0;
`ifdef REDUCE_GATE_COUNT_EN
      cnt_q      <= '0;
      cnt_out_q  <= '0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          grp_q <= grp_d;
          op_q  <= op_d;
          inv_q <= inv_of(in_mode);
          err_q <= illegal_of(in_mode);
`ifdef REDUCE_GATE_COUNT_EN
          cnt_q <= cnt_d;
`endif
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_s_q   <= out_s_d;
          out_err_q <= err_q;
`ifdef REDUCE_GATE_COUNT_EN
          cnt_out_q <= err_q ? '0 : cnt_sum;
`endif
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_s     = out_s_q;
  assign out_err   = out_err_q;
`ifdef REDUCE_GATE_COUNT_EN
  assign out_count = cnt_out_q;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed-vector bench for reduce_gate_pipe (N_INPUTS=7, GROUP=4).
module tb_reduce_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] in_data, in_mask;
  logic [2:0] in_mode;
  logic       in_valid, in_ready;
  logic       out_s, out_err, out_valid, out_ready;
`ifdef REDUCE_GATE_COUNT_EN
  logic [2:0] out_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  reduce_gate_pipe #(.N_INPUTS(7), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_s     (out_s),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef REDUCE_GATE_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stream engine state (stimulus in, observations out; checks live in the tests).
  logic [6:0] q_data[$];
  logic [6:0] q_mask[$];
  logic [2:0] q_mode[$];
  bit         rdy_pat[$];
  bit         obs_s[$];
  bit         obs_e[$];
  int         hold_bad, inrdy_low, total_cyc, first_out;
  bit         timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_s(input logic [6:0] d, input logic [6:0] m, input logic [2:0] md);
    logic acc, b, id;
    if (md > 3'd5) return 1'b0;
    id  = (md == 3'd0) || (md == 3'd3);
    acc = id;
    for (int i = 0; i < 7; i++) begin
      b = m[i] ? d[i] : id;
      case (md % 3)
        0:       acc = acc & b;
        1:       acc = acc | b;
        default: acc = acc ^ b;
      endcase
    end
    return acc ^ (md >= 3'd3);
  endfunction

  task automatic send_one(input logic [6:0] d, input logic [6:0] m, input logic [2:0] md,
                          output logic v1, output logic v2, output logic s, output logic e,
                          output logic [2:0] c);
    in_data = d; in_mask = m; in_mode = md; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    v1 = out_valid;
    tick();
    v2 = out_valid; s = out_s; e = out_err;
`ifdef REDUCE_GATE_COUNT_EN
    c = out_count;
`else
    c = 3'd0;
`endif
    tick();
  endtask

  task automatic run_stream(input int max_cycles);
    int  idx = 0;
    bit  stalled = 1'b0, held_s = 1'b0, held_e = 1'b0, acc;
    obs_s.delete(); obs_e.delete();
    hold_bad = 0; inrdy_low = 0; total_cyc = 0; first_out = -1; timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (idx < q_data.size()) begin
        in_valid = 1'b1; in_data = q_data[idx]; in_mask = q_mask[idx]; in_mode = q_mode[idx];
      end else in_valid = 1'b0;
      out_ready = (c < rdy_pat.size()) ? rdy_pat[c] : 1'b1;
      #1;
      if (stalled && (!out_valid || out_s !== held_s || out_err !== held_e)) hold_bad++;
      if (!in_ready) inrdy_low++;
      if (out_valid && out_ready) begin
        obs_s.push_back(out_s); obs_e.push_back(out_err);
        if (first_out < 0) first_out = c;
      end
      stalled = out_valid && !out_ready;
      held_s = out_s; held_e = out_err;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      if (idx == q_data.size() && obs_s.size() == q_data.size()) begin
        total_cyc = c + 1; timed_out = 1'b0;
        break;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    bit stale;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_s !== 1'b0) begin n_err++; $display("FAIL rst_out_s got=%b exp=0", out_s); end
    n_cmp++; if (out_err !== 1'b0) begin n_err++; $display("FAIL rst_out_err got=%b exp=0", out_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    tick();
    in_data = 7'h7F; in_mask = 7'h7F; in_mode = 3'd0; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_s !== 1'b1) begin n_err++; $display("FAIL midrst_pre got=%b/%b exp=1/1", out_valid, out_s); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_full_ready got=%b exp=0", in_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_s !== 1'b0) begin n_err++; $display("FAIL midrst_out_s got=%b exp=0", out_s); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL rst_stale_output got=%b exp=0", stale); end
  endtask

  task automatic test_modes();
    logic       v1, v2, s, e;
    logic [2:0] c;
    logic [6:0] exp_s;
    exp_s = 7'b0000111;
    for (int md = 0; md <= 6; md++) begin
      send_one(7'h7F, 7'h7F, 3'(md), v1, v2, s, e, c);
      n_cmp++; if (v1 !== 1'b0) begin n_err++; $display("FAIL mode%0d_early_valid got=%b exp=0", md, v1); end
      n_cmp++; if (v2 !== 1'b1) begin n_err++; $display("FAIL mode%0d_valid got=%b exp=1", md, v2); end
      n_cmp++; if (s !== exp_s[md]) begin n_err++; $display("FAIL mode%0d_s got=%b exp=%b", md, s, exp_s[md]); end
      n_cmp++; if (e !== (md == 6)) begin n_err++; $display("FAIL mode%0d_err got=%b exp=%b", md, e, md == 6); end
    end
  endtask

  task automatic test_mask();
    logic [6:0] td[3], tm[3];
    logic [2:0] tmd[3];
    logic       te[3];
    logic       v1, v2, s, e;
    logic [2:0] c;
    td[0] = 7'b0111111; tm[0] = 7'b0111111; tmd[0] = 3'd0; te[0] = 1'b1;
    td[1] = 7'b0111111; tm[1] = 7'h7F;      tmd[1] = 3'd0; te[1] = 1'b0;
    td[2] = 7'b1010101; tm[2] = 7'h00;      tmd[2] = 3'd4; te[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_one(td[i], tm[i], tmd[i], v1, v2, s, e, c);
      n_cmp++; if (v2 !== 1'b1 || s !== te[i]) begin n_err++; $display("FAIL mask%0d got=%b/%b exp=1/%b", i, v2, s, te[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit exp_r[4];
    q_data.delete(); q_mask.delete(); q_mode.delete(); rdy_pat.delete();
    exp_r[0] = 1; exp_r[1] = 0; exp_r[2] = 1; exp_r[3] = 0;
    q_data.push_back(7'h01); q_data.push_back(7'h03); q_data.push_back(7'h07); q_data.push_back(7'h0F);
    for (int i = 0; i < 4; i++) begin q_mask.push_back(7'h7F); q_mode.push_back(3'd2); end
    rdy_pat.push_back(1); rdy_pat.push_back(1);
    rdy_pat.push_back(0); rdy_pat.push_back(0); rdy_pat.push_back(0);
    run_stream(40);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL bp_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (obs_s.size() !== 4) begin n_err++; $display("FAIL bp_count got=%0d exp=4", obs_s.size()); end
    for (int i = 0; i < 4 && i < obs_s.size(); i++) begin
      n_cmp++; if (obs_s[i] !== exp_r[i]) begin n_err++; $display("FAIL bp_res%0d got=%b exp=%b", i, obs_s[i], exp_r[i]); end
    end
    n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL bp_hold got=%0d exp=0", hold_bad); end
    n_cmp++; if (inrdy_low !== 3) begin n_err++; $display("FAIL bp_in_ready_low got=%0d exp=3", inrdy_low); end
    n_cmp++; if (total_cyc !== 9) begin n_err++; $display("FAIL bp_cycles got=%0d exp=9", total_cyc); end
  endtask

  task automatic test_back_to_back();
    q_data.delete(); q_mask.delete(); q_mode.delete(); rdy_pat.delete();
    for (int i = 0; i < 100; i++) begin
      q_data.push_back(7'($urandom));
      q_mask.push_back(7'($urandom));
      q_mode.push_back(3'($urandom_range(0, 7)));
    end
    run_stream(300);
    n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got=%b exp=0", timed_out); end
    n_cmp++; if (first_out !== 2) begin n_err++; $display("FAIL b2b_latency got=%0d exp=2", first_out); end
    n_cmp++; if (total_cyc !== 102) begin n_err++; $display("FAIL b2b_cycles got=%0d exp=102", total_cyc); end
    n_cmp++; if (obs_s.size() !== 100) begin n_err++; $display("FAIL b2b_count got=%0d exp=100", obs_s.size()); end
    for (int i = 0; i < obs_s.size() && i < 100; i++) begin
      n_cmp++;
      if (obs_s[i] !== ref_s(q_data[i], q_mask[i], q_mode[i]) || obs_e[i] !== (q_mode[i] > 3'd5)) begin
        n_err++;
        $display("FAIL b2b_beat%0d got=%b/%b exp=%b/%b", i, obs_s[i], obs_e[i],
                 ref_s(q_data[i], q_mask[i], q_mode[i]), q_mode[i] > 3'd5);
      end
    end
  endtask

`ifdef REDUCE_GATE_COUNT_EN
  task automatic test_count();
    logic       v1, v2, s, e;
    logic [2:0] c;
    send_one(7'h5B, 7'h7F, 3'd0, v1, v2, s, e, c);
    n_cmp++; if (c !== 3'd5) begin n_err++; $display("FAIL count_full got=%0d exp=5", c); end
    send_one(7'h5B, 7'h0F, 3'd1, v1, v2, s, e, c);
    n_cmp++; if (c !== 3'd3) begin n_err++; $display("FAIL count_mask got=%0d exp=3", c); end
    send_one(7'h5B, 7'h7F, 3'd7, v1, v2, s, e, c);
    n_cmp++; if (c !== 3'd0) begin n_err++; $display("FAIL count_err got=%0d exp=0", c); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_data = '0; in_mask = '0; in_mode = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    test_modes();
    test_mask();
    test_backpressure();
    test_back_to_back();
`ifdef REDUCE_GATE_COUNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
